mmio_serial_led: RTL and testbench



---
 rtl/mmio_serial_led_if.sv | 25 ++
 rtl/mmio_serial_led.sv | 195 +++++++++++++++++++
 tb/tb_mmio_serial_led.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_serial_led_if.sv
// CPU data-memory bus as seen by the serial LED register block.
// The CPU side drives the address and write strobe; the peripheral returns combinational read data.
interface mmio_serial_led_if;
    logic [31:0] rw_addr;
    logic [31:0] w_data;
    logic        w_en;
    logic [31:0] r_data;
    logic        r_hit;

    modport master (
        output rw_addr,
        output w_data,
        output w_en,
        input  r_data,
        input  r_hit
    );

    modport slave (
        input  rw_addr,
        input  w_data,
        input  w_en,
        output r_data,
        output r_hit
    );
endinterface

// File: rtl/mmio_serial_led.sv
// Memory-mapped serial LED peripheral: FIFO-buffered words shifted out MSB-first with an idle gap.
// Define MMIO_SERIAL_LED_IRQ_EN to build the completion interrupt (irq_en bit and done flag).
module mmio_serial_led #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_03F0,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          BIT_CYCLES = 4,
    parameter int          GAP_CYCLES = 8
) (
    input  logic              clock,
    input  logic              reset,
    mmio_serial_led_if.slave  bus,
    output logic              ser_out,
    output logic              ser_active,
    output logic [DATA_W-1:0] out_data,
    output logic              irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;

    logic [1:0]        state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic [DATA_W-1:0] word_reg;
    logic [DW-1:0]     div_reg;
    logic [BW-1:0]     bit_reg;
    logic [GW-1:0]     gap_reg;

    logic              enable_reg;
    logic              overflow_reg;
    logic              irq_en_bit;

    logic data_sel, status_sel, ctrl_sel;
    logic data_wr, ctrl_wr;
    logic empty, full, push, pop, busy;
    logic bit_done, word_done, gap_done;
    logic [DATA_W-1:0] head_word;
    logic unused_bus;

    assign data_sel   = (bus.rw_addr == BASE_ADDR);
    assign status_sel = (bus.rw_addr == BASE_ADDR + 32'd4);
    assign ctrl_sel   = (bus.rw_addr == BASE_ADDR + 32'd8);
    assign data_wr    = bus.w_en && data_sel;
    assign ctrl_wr    = bus.w_en && ctrl_sel;
    assign unused_bus = ^bus.w_data;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(FIFO_DEPTH));
    assign busy      = (state_reg != ST_IDLE);
    // A full FIFO rejects the push even when the engine pops in the same cycle.
    assign push      = data_wr && !full;
    assign pop       = (state_reg == ST_IDLE) && enable_reg && !empty;
    assign head_word = fifo_mem[rd_ptr_reg];

    assign bit_done  = (state_reg == ST_SHIFT) && (div_reg == DW'(BIT_CYCLES - 1));
    assign word_done = bit_done && (bit_reg == BW'(DATA_W - 1));
    assign gap_done  = (state_reg == ST_GAP) && (gap_reg == GW'(GAP_CYCLES - 1));

    assign ser_active = (state_reg == ST_SHIFT);
    assign ser_out    = (state_reg == ST_SHIFT) && shreg_reg[DATA_W-1];

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= bus.w_data[DATA_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (ctrl_wr)
                enable_reg <= bus.w_data[0];
            if (data_wr && full)
                overflow_reg <= 1'b1;
            else if (ctrl_wr && bus.w_data[1])
                overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            shreg_reg <= '0;
            word_reg  <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            gap_reg   <= '0;
            out_data  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        shreg_reg <= head_word;
                        word_reg  <= head_word;
                        div_reg   <= '0;
                        bit_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_done) begin
                        div_reg <= '0;
                        if (word_done) begin
                            out_data  <= word_reg;
                            gap_reg   <= '0;
                            state_reg <= ST_GAP;
                        end else begin
                            shreg_reg <= shreg_reg << 1;
                            bit_reg   <= bit_reg + BW'(1);
                        end
                    end else begin
                        div_reg <= div_reg + DW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_done)
                        state_reg <= ST_IDLE;
                    else
                        gap_reg <= gap_reg + GW'(1);
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef MMIO_SERIAL_LED_IRQ_EN
    logic irq_en_reg;
    logic done_reg;
    logic irq_reg;

    // A new DATA write means software has more work queued, so it retires the done flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (ctrl_wr)
                irq_en_reg <= bus.w_data[2];
            if (data_wr)
                done_reg <= 1'b0;
            else if (gap_done)
                done_reg <= 1'b1;
            irq_reg <= irq_en_reg && enable_reg && empty && (state_reg == ST_IDLE) && done_reg;
        end
    end

    assign irq_en_bit = irq_en_reg;
    assign irq        = irq_reg;
`else
    assign irq_en_bit = 1'b0;
    assign irq        = 1'b0;
`endif

    logic [31:0] status_word;
    logic [31:0] ctrl_word;

    assign status_word = {16'b0, 8'(count_reg), 4'b0, overflow_reg, full, empty, busy};
    assign ctrl_word   = {29'b0, irq_en_bit, 1'b0, enable_reg};

    assign bus.r_hit  = status_sel || ctrl_sel;
    assign bus.r_data = status_sel ? status_word :
                        ctrl_sel   ? ctrl_word   : 32'b0;
endmodule

// File: tb/tb_mmio_serial_led.sv
// Self-checking bench for mmio_serial_led: randomized words checked against a waveform model.
// Compile with MMIO_SERIAL_LED_IRQ_EN defined to exercise the interrupt path.
module tb_mmio_serial_led;
    localparam logic [31:0] BASE       = 32'h0000_03F0;
    localparam int          DATA_W     = 8;
    localparam int          FIFO_DEPTH = 4;
    localparam int          BIT_CYCLES = 4;
    localparam int          GAP_CYCLES = 8;
    localparam int          SHIFT_CYC  = DATA_W * BIT_CYCLES;
    localparam int          SLOT       = SHIFT_CYC + GAP_CYCLES + 1;
    localparam logic [31:0] A_DATA     = BASE;
    localparam logic [31:0] A_STATUS   = BASE + 32'd4;
    localparam logic [31:0] A_CTRL     = BASE + 32'd8;

    logic              clock;
    logic              reset;
    logic              ser_out;
    logic              ser_active;
    logic [DATA_W-1:0] out_data;
    logic              irq;

    int checks = 0;
    int passed = 0;

    mmio_serial_led_if bus ();

    mmio_serial_led #(
        .BASE_ADDR  (BASE),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BIT_CYCLES (BIT_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus.slave),
        .ser_out    (ser_out),
        .ser_active (ser_active),
        .out_data   (out_data),
        .irq        (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected line level s clocks into a word's slot: each bit held BIT_CYCLES, then low.
    function automatic logic exp_ser(input logic [DATA_W-1:0] w, input int s);
        if (s < SHIFT_CYC)
            return w[DATA_W - 1 - s / BIT_CYCLES];
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_status(input int cnt, input logic ovf, input logic bsy);
        return {16'b0, 8'(cnt), 4'b0, ovf, (cnt == FIFO_DEPTH), (cnt == 0), bsy};
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        bus.rw_addr = a;
        bus.w_data  = d;
        bus.w_en    = 1'b1;
        @(negedge clock);
        bus.w_en    = 1'b0;
        bus.rw_addr = 32'h0;
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        bus.rw_addr = a;
        #1;
        d = bus.r_data;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.w_en   = 1'b0;
        bus.rw_addr = 32'h0;
        bus.w_data = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        bus_write(A_CTRL, 32'h1);
        bus_write(A_DATA, 32'hA5);
        repeat (10) @(negedge clock);
        checks++;
        if (ser_active !== 1'b1) $display("FAIL reset_pre_active got=%b want=1", ser_active);
        else passed++;
        bus.rw_addr = A_STATUS;
        reset = 1'b1;
        #1;
        checks++;
        if (ser_out !== 1'b0 || ser_active !== 1'b0)
            $display("FAIL reset_serial got ser_out=%b ser_active=%b want 0 0", ser_out, ser_active);
        else passed++;
        checks++;
        if (bus.r_data !== 32'h0000_0002) $display("FAIL reset_status got=%h want=00000002", bus.r_data);
        else passed++;
        checks++;
        if (out_data !== '0) $display("FAIL reset_out_data got=%h want=00", out_data);
        else passed++;
        read_reg(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0 || irq !== 1'b0) $display("FAIL reset_ctrl got ctrl=%h irq=%b want 0 0", rd, irq);
        else passed++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        logic [7:0] w = 8'hA5;
        int errs = 0;
        logic [DATA_W-1:0] od_before = '0;
        logic [31:0] rd;
        do_reset();
        bus_write(A_CTRL, 32'h1);
        bus_write(A_DATA, {24'h0, w});
        for (int s = 0; s < SLOT; s++) begin
            @(negedge clock);
            if (s < SHIFT_CYC) begin
                checks++;
                if (ser_out !== exp_ser(w, s) || ser_active !== 1'b1)
                    $display("FAIL single_bit clk=%0d got=%b/%b want=%b/1", s, ser_out, ser_active, exp_ser(w, s));
                else passed++;
            end else if (ser_out !== 1'b0 || ser_active !== 1'b0) begin
                errs++;
            end
            if (s == SHIFT_CYC - 1) od_before = out_data;
        end
        checks++;
        if (od_before !== '0) $display("FAIL single_out_early got=%h want=00", od_before);
        else passed++;
        checks++;
        if (out_data !== w) $display("FAIL single_out_data got=%h want=%h", out_data, w);
        else passed++;
        checks++;
        if (errs != 0) $display("FAIL single_gap_low got=%0d high clocks want=0", errs);
        else passed++;
        read_reg(A_STATUS, rd);
        checks++;
        if (rd !== exp_status(0, 1'b0, 1'b0)) $display("FAIL single_idle_status got=%h want=%h", rd, exp_status(0, 1'b0, 1'b0));
        else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [DATA_W-1:0] last_out = '0;
        do_reset();
        for (int i = 1; i <= 5; i++) bus_write(A_DATA, 32'(i));
        read_reg(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0000_040C) $display("FAIL overflow_status got=%h want=0000040C", rd);
        else passed++;
        bus_write(A_CTRL, 32'h3);
        read_reg(A_STATUS, rd);
        checks++;
        if (rd !== exp_status(4, 1'b0, 1'b0)) $display("FAIL overflow_clear got=%h want=%h", rd, exp_status(4, 1'b0, 1'b0));
        else passed++;
        for (int k = 1; k <= 4; k++) begin
            int errs = 0;
            logic [DATA_W-1:0] od_before = '0;
            logic [DATA_W-1:0] od_after = '0;
            for (int s = 0; s < SLOT; s++) begin
                @(negedge clock);
                if (ser_out !== exp_ser(DATA_W'(k), s) || ser_active !== (s < SHIFT_CYC)) errs++;
                if (s == SHIFT_CYC - 1) od_before = out_data;
                if (s == SHIFT_CYC) od_after = out_data;
            end
            checks++;
            if (errs != 0 || od_before !== last_out || od_after !== DATA_W'(k))
                $display("FAIL overflow_word%0d got errs=%0d out=%h->%h want 0 %h->%h", k, errs, od_before, od_after, last_out, DATA_W'(k));
            else passed++;
            last_out = DATA_W'(k);
        end
        repeat (2 * SLOT) begin
            @(negedge clock);
            checks++;
            if (ser_active !== 1'b0) $display("FAIL overflow_no_fifth got=%b want=0", ser_active);
            else passed++;
        end
        read_reg(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0000_0002 || out_data !== 8'h04) $display("FAIL overflow_final got=%h/%h want=00000002/04", rd, out_data);
        else passed++;
    endtask

    task automatic test_enable_drop();
        logic [DATA_W-1:0] w0 = DATA_W'($urandom);
        logic [DATA_W-1:0] w1 = DATA_W'($urandom);
        logic [31:0] rd;
        int errs = 0;
        do_reset();
        bus_write(A_DATA, 32'(w0));
        bus_write(A_DATA, 32'(w1));
        bus_write(A_CTRL, 32'h1);
        for (int s = 0; s < SLOT; s++) begin
            @(negedge clock);
            if (s == 9) begin
                bus.rw_addr = A_CTRL;
                bus.w_data  = 32'h0;
                bus.w_en    = 1'b1;
            end else if (s == 10) begin
                bus.w_en    = 1'b0;
                bus.rw_addr = 32'h0;
                $display("write addr=%h data=%h", A_CTRL, 32'h0);
            end
            if (ser_out !== exp_ser(w0, s) || ser_active !== (s < SHIFT_CYC)) errs++;
            if (s == SHIFT_CYC) begin
                checks++;
                if (out_data !== w0) $display("FAIL drop_out_data got=%h want=%h", out_data, w0);
                else passed++;
            end
        end
        checks++;
        if (errs != 0) $display("FAIL drop_waveform got=%0d bad clocks want=0", errs);
        else passed++;
        read_reg(A_STATUS, rd);
        checks++;
        if (rd !== exp_status(1, 1'b0, 1'b0)) $display("FAIL drop_status got=%h want=%h", rd, exp_status(1, 1'b0, 1'b0));
        else passed++;
        errs = 0;
        repeat (2 * SLOT) begin
            @(negedge clock);
            if (ser_active !== 1'b0) errs++;
        end
        read_reg(A_STATUS, rd);
        checks++;
        if (errs != 0 || rd !== exp_status(1, 1'b0, 1'b0) || out_data !== w0)
            $display("FAIL drop_held got errs=%0d status=%h out=%h want 0 %h %h", errs, rd, out_data, exp_status(1, 1'b0, 1'b0), w0);
        else passed++;
    endtask

    task automatic test_bus_decode();
        logic [31:0] rd;
        logic [31:0] v;
        do_reset();
        bus.rw_addr = A_STATUS; #1;
        checks++;
        if (bus.r_hit !== 1'b1) $display("FAIL decode_status_hit got=%b want=1", bus.r_hit);
        else passed++;
        bus.rw_addr = A_CTRL; #1;
        checks++;
        if (bus.r_hit !== 1'b1) $display("FAIL decode_ctrl_hit got=%b want=1", bus.r_hit);
        else passed++;
        bus.rw_addr = A_DATA; #1;
        checks++;
        if (bus.r_hit !== 1'b0 || bus.r_data !== 32'h0) $display("FAIL decode_data_miss got=%b/%h want=0/0", bus.r_hit, bus.r_data);
        else passed++;
        bus.rw_addr = 32'h0000_0400; #1;
        checks++;
        if (bus.r_hit !== 1'b0 || bus.r_data !== 32'h0) $display("FAIL decode_far_miss got=%b/%h want=0/0", bus.r_hit, bus.r_data);
        else passed++;
        bus_write(BASE + 32'd1, 32'hFF);
        bus_write(BASE + 32'd9, 32'h7);
        read_reg(A_STATUS, rd);
        checks++;
        if (rd !== 32'h0000_0002) $display("FAIL decode_misaligned_data got=%h want=00000002", rd);
        else passed++;
        read_reg(A_CTRL, rd);
        checks++;
        if (rd !== 32'h0) $display("FAIL decode_misaligned_ctrl got=%h want=0", rd);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            v[0] = 1'b0;
            bus_write(A_CTRL, v);
            read_reg(A_CTRL, rd);
            checks++;
`ifdef MMIO_SERIAL_LED_IRQ_EN
            if (rd !== {29'b0, v[2], 2'b00}) $display("FAIL decode_ctrl_rb got=%h want=%h", rd, {29'b0, v[2], 2'b00});
`else
            if (rd !== 32'h0) $display("FAIL decode_ctrl_rb got=%h want=0", rd);
`endif
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] q [$];
        logic [DATA_W-1:0] last_out = '0;
        logic [31:0] rd;
        do_reset();
        for (int it = 0; it < 3; it++) begin
            int n = $urandom_range(2, FIFO_DEPTH);
            q.delete();
            for (int i = 0; i < n; i++) begin
                q.push_back(DATA_W'($urandom));
                bus_write(A_DATA, 32'(q[i]));
            end
            read_reg(A_STATUS, rd);
            checks++;
            if (rd !== exp_status(n, 1'b0, 1'b0)) $display("FAIL b2b_fill got=%h want=%h", rd, exp_status(n, 1'b0, 1'b0));
            else passed++;
            bus_write(A_CTRL, 32'h1);
            while (q.size() > 0) begin
                logic [DATA_W-1:0] w = q.pop_front();
                int errs = 0;
                logic [DATA_W-1:0] od_before = '0;
                logic [DATA_W-1:0] od_after = '0;
                for (int s = 0; s < SLOT; s++) begin
                    @(negedge clock);
                    if (ser_out !== exp_ser(w, s) || ser_active !== (s < SHIFT_CYC)) errs++;
                    if (s == SHIFT_CYC - 1) od_before = out_data;
                    if (s == SHIFT_CYC) od_after = out_data;
                end
                checks++;
                if (errs != 0 || od_before !== last_out || od_after !== w)
                    $display("FAIL b2b_word got errs=%0d out=%h->%h want 0 %h->%h", errs, od_before, od_after, last_out, w);
                else passed++;
                last_out = w;
            end
            bus_write(A_CTRL, 32'h0);
        end
    endtask

    task automatic test_irq();
        logic [DATA_W-1:0] w = DATA_W'($urandom);
        int errs = 0;
        do_reset();
        bus_write(A_CTRL, 32'h5);
        bus_write(A_DATA, 32'(w));
`ifdef MMIO_SERIAL_LED_IRQ_EN
        for (int s = 0; s <= SLOT; s++) begin
            @(negedge clock);
            if (s < SLOT && irq !== 1'b0) errs++;
        end
        checks++;
        if (errs != 0) $display("FAIL irq_early got=%0d high clocks want=0", errs);
        else passed++;
        checks++;
        if (irq !== 1'b1) $display("FAIL irq_rise got=%b want=1", irq);
        else passed++;
        bus_write(A_DATA, 32'(~w));
        checks++;
        if (irq !== 1'b1) $display("FAIL irq_hold got=%b want=1", irq);
        else passed++;
        @(negedge clock);
        checks++;
        if (irq !== 1'b0) $display("FAIL irq_drop got=%b want=0", irq);
        else passed++;
`else
        for (int s = 0; s < 2 * SLOT; s++) begin
            @(negedge clock);
            if (irq !== 1'b0) errs++;
        end
        checks++;
        if (errs != 0 || out_data !== w) $display("FAIL irq_tied got=%0d high/out=%h want=0/%h", errs, out_data, w);
        else passed++;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        bus.w_en    = 1'b0;
        bus.rw_addr = 32'h0;
        bus.w_data  = 32'h0;
        test_reset();
        test_single_word();
        test_overflow();
        test_enable_drop();
        test_bus_decode();
        test_back_to_back();
        test_irq();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
